// File: rtl/riscv_alu_seq.sv
// riscv_alu_seq: multi-cycle RISC-V ALU, 1-cycle simple ops, iterative MUL/MULHU.
// Define RISCV_ALU_DIV_EN to add an unsigned restoring DIVU/REMU engine.
module riscv_alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      ALUctl,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] ALUout,
    output logic            zero
);
    localparam int SHW = $clog2(XLEN);
`ifdef RISCV_ALU_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DONE, DIV} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif
    state_t            state, state_n;
    logic [SHW-1:0]    sh, cnt;
    logic [XLEN-1:0]   simple, m, fin;
    logic [2*XLEN-1:0] p, p_mul, p_nx;
    logic [XLEN:0]     msum;
    logic              acc, is_mul, is_div, hi, last;
    assign ready  = state == IDLE || state == DONE;
    assign done   = state == DONE;
    assign acc    = start && ready;
    assign is_mul = ALUctl == 4'd10 || ALUctl == 4'd11;
    assign sh     = B[SHW-1:0];
    assign last   = cnt == SHW'(XLEN - 1);
    always_comb begin
        simple = '0;
        case (ALUctl)
            4'd0:    simple = A & B;
            4'd1:    simple = A | B;
            4'd2:    simple = A + B;
            4'd3:    simple = A ^ B;
            4'd4:    simple = A << sh;
            4'd5:    simple = A >> sh;
            4'd6:    simple = A - B;
            4'd7:    simple = XLEN'($signed(A) < $signed(B));
            4'd8:    simple = $signed(A) >>> sh;
            4'd9:    simple = XLEN'(A < B);
            4'd12:   simple = ~(A | B);
            default: simple = '0;
        endcase
    end
    // p = {high partial, multiplier}; each step adds the multiplicand then shifts right
    assign msum  = {1'b0, p[2*XLEN-1:XLEN]} + {1'b0, p[0] ? m : {XLEN{1'b0}}};
    assign p_mul = {msum, p[XLEN-1:1]};
`ifdef RISCV_ALU_DIV_EN
    logic [XLEN:0]   t;
    logic [XLEN-1:0] d;
    logic            ge;
    // p = {remainder, quotient/dividend}; B==0 naturally yields all-ones and A
    assign is_div = ALUctl == 4'd13 || ALUctl == 4'd14;
    assign busy   = state == MUL || state == DIV;
    assign t      = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    assign ge     = t >= {1'b0, m};
    assign d      = t[XLEN-1:0] - m;
    assign p_nx   = state == DIV ? {ge ? d : t[XLEN-1:0], p[XLEN-2:0], ge} : p_mul;
`else
    assign is_div = 1'b0;
    assign busy   = state == MUL;
    assign p_nx   = p_mul;
`endif
    assign fin = hi ? p_nx[2*XLEN-1:XLEN] : p_nx[XLEN-1:0];
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
`ifdef RISCV_ALU_DIV_EN
            IDLE, DONE: state_n = !acc ? IDLE : is_mul ? MUL : is_div ? DIV : DONE;
            DIV:        state_n = last ? DONE : DIV;
`else
            IDLE, DONE: state_n = !acc ? IDLE : is_mul ? MUL : DONE;
`endif
            MUL:        state_n = last ? DONE : MUL;
            default:    state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ALUout <= '0;
            zero   <= 1'b0;
            p      <= '0;
            m      <= '0;
            cnt    <= '0;
            hi     <= 1'b0;
        end else if (acc) begin
            cnt <= '0;
            hi  <= ALUctl == 4'd11 || ALUctl == 4'd14;
            m   <= is_div ? B : A;
            p   <= {{XLEN{1'b0}}, is_div ? A : B};
            if (!is_mul && !is_div) begin
                ALUout <= simple;
                zero   <= simple == '0;
            end
        end else if (busy) begin
            p   <= p_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                ALUout <= fin;
                zero   <= fin == '0;
            end
        end
    end
endmodule
